// File: rtl/execute_muldiv.sv
// Execute stage with E/M pipeline register and an iterative mul/div/rem unit.
// Optional feature macro: MULDIV_EN. When it is defined, the iterative unit and its
// FSM are built. When it is undefined, ops 100/101/110 complete in one cycle with
// result 0, and stall_e is tied low.
module execute_muldiv #(
    parameter int WIDTH    = 24,
    parameter int REG_BITS = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid_e,
    input  logic                i_flush_e,
    input  logic [2:0]          i_alu_control_e,
    input  logic [WIDTH-1:0]    i_src_a_e,
    input  logic [WIDTH-1:0]    i_src_b_e,
    input  logic [WIDTH-1:0]    i_write_data_e,
    input  logic [REG_BITS-1:0] i_write_register_e,
    input  logic                i_reg_write_e,
    input  logic                i_mem_write_e,
    input  logic                i_mem_to_reg_e,
    output logic                o_stall_e,
    output logic [WIDTH-1:0]    o_alu_result_m,
    output logic [WIDTH-1:0]    o_write_data_m,
    output logic [REG_BITS-1:0] o_write_register_m,
    output logic                o_reg_write_m,
    output logic                o_mem_write_m,
    output logic                o_mem_to_reg_m,
    output logic                o_div_by_zero_m
);
    logic [WIDTH-1:0]    w_single;
    logic [4:0]          w_shamt;
    logic                w_mc_done;
    logic [WIDTH-1:0]    w_mc_result;
    logic                w_mc_dbz;
    logic [WIDTH-1:0]    w_mc_wd;
    logic [REG_BITS-1:0] w_mc_wreg;
    logic                w_mc_rw;
    logic                w_mc_mw;
    logic                w_mc_m2r;

    assign w_shamt = i_src_b_e[4:0];

    // Single-cycle ALU. Ops 100/101/110 give 0 here; with the iterative unit they never take this path.
    always_comb begin
        w_single = '0;
        case (i_alu_control_e)
            3'b000: w_single = i_src_a_e + i_src_b_e;
            3'b001: w_single = i_src_a_e - i_src_b_e;
            3'b010: w_single = i_src_a_e & i_src_b_e;
            3'b011: w_single = i_src_a_e | i_src_b_e;
            3'b111: w_single = (int'(w_shamt) >= WIDTH) ? '0 : (i_src_a_e << w_shamt);
            default: w_single = '0;
        endcase
    end

`ifdef MULDIV_EN
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
    localparam logic [WIDTH-1:0] LAST = WIDTH'(WIDTH - 1);

    state_t              r_state, w_next;
    logic [WIDTH-1:0]    r_count;
    logic [WIDTH-1:0]    r_acc;   // product accumulator / partial remainder
    logic [WIDTH-1:0]    r_opa;   // multiplicand (shifts left) / dividend becoming quotient
    logic [WIDTH-1:0]    r_opb;   // multiplier (shifts right) / divisor
    logic [2:0]          r_op;
    logic                r_dbz;
    logic [WIDTH-1:0]    r_wd;
    logic [REG_BITS-1:0] r_wreg;
    logic                r_rw, r_mw, r_m2r;
    logic                w_is_mc, w_start, w_b_zero;
    logic [WIDTH:0]      w_rem_sh, w_diff;

    assign w_is_mc  = i_alu_control_e[2] & ~(i_alu_control_e[1] & i_alu_control_e[0]);
    assign w_start  = (r_state == S_IDLE) & i_valid_e & w_is_mc & ~i_flush_e;
    assign w_b_zero = (i_src_b_e == '0) & (i_alu_control_e != 3'b100);
    assign w_rem_sh = {r_acc, r_opa[WIDTH-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_opb};

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic; a flush aborts any in-flight operation
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_start) w_next = w_b_zero ? S_DONE : S_BUSY;
            S_BUSY: if (i_flush_e) w_next = S_IDLE;
                    else if (r_count == LAST) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Stall output: the starting cycle and all of BUSY, never while in reset
    always_comb begin
        o_stall_e = 1'b0;
        if (!i_rst) begin
            case (r_state)
                S_IDLE:  o_stall_e = w_start;
                S_BUSY:  o_stall_e = 1'b1;
                default: o_stall_e = 1'b0;
            endcase
        end
    end

    // Iterative datapath: one shift-add or restoring-divide step per BUSY cycle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (w_start) begin
            r_count <= '0;
            r_op    <= i_alu_control_e;
            r_opb   <= i_src_b_e;
            r_dbz   <= w_b_zero;
            r_wd    <= i_write_data_e;
            r_wreg  <= i_write_register_e;
            r_rw    <= i_reg_write_e;
            r_mw    <= i_mem_write_e;
            r_m2r   <= i_mem_to_reg_e;
            // Divisor 0: quotient preloaded to all ones, remainder to the dividend
            r_acc   <= w_b_zero ? i_src_a_e : '0;
            r_opa   <= w_b_zero ? '1 : i_src_a_e;
        end else if (r_state == S_BUSY) begin
            r_count <= r_count + 1'b1;
            if (r_op == 3'b100) begin
                r_acc <= r_acc + (r_opb[0] ? r_opa : '0);
                r_opa <= r_opa << 1;
                r_opb <= r_opb >> 1;
            end else if (!w_diff[WIDTH]) begin
                r_acc <= w_diff[WIDTH-1:0];
                r_opa <= {r_opa[WIDTH-2:0], 1'b1};
            end else begin
                r_acc <= w_rem_sh[WIDTH-1:0];
                r_opa <= {r_opa[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign w_mc_done   = (r_state == S_DONE);
    assign w_mc_result = (r_op == 3'b101) ? r_opa : r_acc;
    assign w_mc_dbz    = r_dbz;
    assign w_mc_wd     = r_wd;
    assign w_mc_wreg   = r_wreg;
    assign w_mc_rw     = r_rw;
    assign w_mc_mw     = r_mw;
    assign w_mc_m2r    = r_m2r;
`else
    assign o_stall_e   = 1'b0;
    assign w_mc_done   = 1'b0;
    assign w_mc_result = '0;
    assign w_mc_dbz    = 1'b0;
    assign w_mc_wd     = '0;
    assign w_mc_wreg   = '0;
    assign w_mc_rw     = 1'b0;
    assign w_mc_mw     = 1'b0;
    assign w_mc_m2r    = 1'b0;
`endif

    // E/M register: bubble on stall/flush/invalid, iterative result in DONE, else ALU result
    always_ff @(posedge i_clk) begin
        if (i_rst || o_stall_e || i_flush_e || !i_valid_e) begin
            o_alu_result_m     <= '0;
            o_write_data_m     <= '0;
            o_write_register_m <= '0;
            o_reg_write_m      <= 1'b0;
            o_mem_write_m      <= 1'b0;
            o_mem_to_reg_m     <= 1'b0;
            o_div_by_zero_m    <= 1'b0;
        end else if (w_mc_done) begin
            o_alu_result_m     <= w_mc_result;
            o_write_data_m     <= w_mc_wd;
            o_write_register_m <= w_mc_wreg;
            o_reg_write_m      <= w_mc_rw;
            o_mem_write_m      <= w_mc_mw;
            o_mem_to_reg_m     <= w_mc_m2r;
            o_div_by_zero_m    <= w_mc_dbz;
        end else begin
            o_alu_result_m     <= w_single;
            o_write_data_m     <= i_write_data_e;
            o_write_register_m <= i_write_register_e;
            o_reg_write_m      <= i_reg_write_e;
            o_mem_write_m      <= i_mem_write_e;
            o_mem_to_reg_m     <= i_mem_to_reg_e;
            o_div_by_zero_m    <= 1'b0;
        end
    end
endmodule

// File: doc/execute_muldiv.md
# execute_muldiv

Execute stage of the 24-bit pipelined processor, including the E/M pipeline register that drives the memory stage's address, store-data and write-enable inputs. Single-cycle ALU ops pass through in one cycle. Multiply, divide and remainder run on an iterative shift-add/restoring unit that stalls the front of the pipeline. While stalled, the block sends bubbles to the memory stage so that stores are never repeated.

## Interface
- WIDTH, 24, datapath width
- REG_BITS, 4, register-address width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- valid_e  in  1  instruction in execute is valid
- flush_e  in  1  kill the instruction in execute (taken branch)
- alu_control_e  in  3  000 add, 001 sub, 010 and, 011 orr, 100 mul, 101 div, 110 rem, 111 lsl
- src_a_e, src_b_e  in  WIDTH  operands
- write_data_e  in  WIDTH  store data
- write_register_e  in  REG_BITS  destination register
- reg_write_e, mem_write_e, mem_to_reg_e  in  1  control bits
- stall_e  out  1  hold fetch/decode/execute inputs stable
- alu_result_m, write_data_m  out  WIDTH  E/M register: address/result, store data
- write_register_m  out  REG_BITS  E/M register
- reg_write_m, mem_write_m, mem_to_reg_m  out  1  E/M register
- div_by_zero_m  out  1  E/M register: div/rem had divisor 0

## Operation
- Single-cycle ops:
  - Result is `src_a op src_b`, wrapping modulo 2^WIDTH.
  - For lsl, the shift amount is `src_b[4:0]`; shifts of WIDTH or more give 0.
- Multi-cycle ops (100/101/110) are unsigned:
  - mul returns the low WIDTH bits of the product.
  - div returns the quotient; rem returns the remainder.
- Start condition: state IDLE, valid_e=1, op is multi-cycle, and flush_e=0.
  - Operands and control are latched.
  - A WIDTH-bit iteration counter is cleared.
- Divisor 0 (div/rem):
  - The block skips BUSY and goes directly to DONE.
  - Quotient is all ones; remainder is the dividend; div_by_zero_m=1.
- FSM states and transitions:
  - IDLE → BUSY on start, or IDLE → DONE on start with divisor 0.
  - BUSY → DONE when count = WIDTH-1.
  - DONE → IDLE always.
- stall_e is high in IDLE when start is true, and for the whole of BUSY. It is low in DONE.
- E/M register loads per cycle:
  - A bubble (reg_write_m = mem_write_m = mem_to_reg_m = 0, other fields 0) when stall_e=1, flush_e=1, or valid_e=0.
  - The multi-cycle result plus latched control in DONE.
  - Otherwise, the single-cycle result plus control.
- flush_e during BUSY or DONE aborts the operation: the next state is IDLE and a bubble enters E/M.
- rst at any time, including mid-BUSY:
  - State goes to IDLE and the counter is cleared.
  - All E/M outputs reset to 0; stall_e is forced to 0 while rst=1.

## Timing
- Single-cycle op presented in cycle 0: result appears on the `_m` outputs in cycle 1.
- Multi-cycle op presented in cycle 0:
  - stall_e is high in cycles 0..WIDTH, i.e. 25 cycles.
  - DONE is cycle WIDTH+1.
  - Result appears on the `_m` outputs in cycle WIDTH+2 (cycle 26).
  - `_m` outputs carry bubbles in cycles 1..WIDTH+1.
- Divide-by-zero: stall_e is high in cycle 0 only; DONE is cycle 1; result appears in cycle 2.
- Upstream must hold all `_e` inputs constant while stall_e=1. Only flush_e may change.
- A new op may be presented in the cycle immediately after DONE, so back-to-back multi-cycle ops are allowed.
- No combinational path exists from `_e` inputs to `_m` outputs. stall_e is combinational from valid_e, alu_control_e, flush_e and state.

## Configuration
- MULDIV_EN defined: the iterative unit and FSM are built as described above.
- MULDIV_EN undefined:
  - No FSM or counter is built, and stall_e is tied to 0.
  - Ops 100/101/110 complete in one cycle with result 0 and div_by_zero_m=0.

## Test plan
- add 0x7FFFFF + 0x000001 → alu_result_m = 0x800000 next cycle. Store op: write_data_e = 0x0000AB → write_data_m = 0x0000AB, mem_write_m=1.
- mul 0x000123 × 0x000010:
  - stall_e high for exactly 25 cycles.
  - mem_write_m and reg_write_m are 0 throughout.
  - alu_result_m = 0x001230 in cycle 26.
- div 0x000064 / 0x000007 → 0x00000E. rem with the same operands → 0x000002. mul 0xFFFFFF × 0x000002 → 0xFFFFFE.
- div 0x000064 / 0 → stall for 1 cycle, alu_result_m = 0xFFFFFF, div_by_zero_m=1. rem 0x000064 / 0 → alu_result_m = 0x000064, div_by_zero_m=1.
- Assert flush_e in BUSY cycle 10 → IDLE next cycle, stall_e drops, only bubbles reach M. Assert rst in BUSY cycle 5 → all `_m` = 0 and stall_e = 0 after the edge.
- Build without MULDIV_EN: mul 0x000003 × 0x000004 → alu_result_m = 0 in cycle 1, stall_e never asserts.
